// File: rtl/video_pattern_gen.sv
// Video test-pattern source: frame-latched mode/colour, optional per-frame
// horizontal scroll, 2-cycle pipeline with syncs delayed to match pixel data.
module video_pattern_gen #(
  parameter int H_ACTIVE    = 1280,
  parameter int V_ACTIVE    = 720,
  parameter int COLOR_W     = 8,
  parameter int TILE_LOG2   = 5,
  parameter int GRID_LOG2   = 6,
  parameter int SCROLL_STEP = 4
) (
  input  logic                   clk_pixel_in,
  input  logic                   rst_in,
  input  logic [10:0]            hcount_in,
  input  logic [9:0]             vcount_in,
  input  logic                   hs_in,
  input  logic                   vs_in,
  input  logic                   ad_in,
  input  logic                   nf_in,
  input  logic [2:0]             mode_in,
  input  logic [3*COLOR_W-1:0]   color_in,
  input  logic                   scroll_en_in,
  output logic [COLOR_W-1:0]     red_out,
  output logic [COLOR_W-1:0]     green_out,
  output logic [COLOR_W-1:0]     blue_out,
  output logic                   hs_out,
  output logic                   vs_out,
  output logic                   ad_out
);
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int CW3   = 3 * COLOR_W;
  localparam logic [10:0] BAR_LAST = 11'(BAR_W - 1);
  localparam logic [10:0] STEP     = 11'(SCROLL_STEP);

  // frame-latched shadows and scroll offset
  logic [2:0]     r_mode;
  logic [CW3-1:0] r_color;
  logic [10:0]    r_off;

  // running bar counter: pixel-in-bar count and bar index of previous pixel
  logic [10:0] r_bar_cnt;
  logic [2:0]  r_bar_idx;
  logic [10:0] w_bar_cnt;
  logic [2:0]  w_bar_idx;
  logic [10:0] w_hx;

  // stage 1
  logic [10:0]    r_s1_hx;
  logic [9:0]     r_s1_vc;
  logic [2:0]     r_s1_bar;
  logic [2:0]     r_s1_mode;
  logic [CW3-1:0] r_s1_color;

  // {hs,vs,ad} delay line; index 0 = stage 1, index 1 = stage 2
  logic [1:0][2:0] r_sync_pipe;

  // stage 2
  logic [COLOR_W-1:0] r_s2_r, r_s2_g, r_s2_b;
  logic [COLOR_W-1:0] w_r, w_g, w_b;

  assign w_hx = hcount_in + r_off;

  always_comb begin
    w_bar_cnt = r_bar_cnt + 11'd1;
    w_bar_idx = r_bar_idx;
    if (hcount_in == 11'd0) begin
      w_bar_cnt = '0;
      w_bar_idx = '0;
    end else if (r_bar_cnt == BAR_LAST) begin
      w_bar_cnt = '0;
      if (r_bar_idx != 3'd7) w_bar_idx = r_bar_idx + 3'd1;
    end
  end

  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      r_mode    <= '0;
      r_color   <= '0;
      r_off     <= '0;
      r_bar_cnt <= '0;
      r_bar_idx <= '0;
    end else begin
      r_bar_cnt <= w_bar_cnt;
      r_bar_idx <= w_bar_idx;
      if (nf_in) begin
        r_mode  <= mode_in;
        r_color <= color_in;
        if (scroll_en_in) r_off <= r_off + STEP;
      end
    end
  end

  // Mode/colour travel with the pixel so a pixel sampled on the nf_in cycle
  // still renders with the old frame's settings.
  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      r_s1_hx     <= '0;
      r_s1_vc     <= '0;
      r_s1_bar    <= '0;
      r_s1_mode   <= '0;
      r_s1_color  <= '0;
      r_sync_pipe <= '0;
    end else begin
      r_s1_hx     <= w_hx;
      r_s1_vc     <= vcount_in;
      r_s1_bar    <= w_bar_idx;
      r_s1_mode   <= r_mode;
      r_s1_color  <= r_color;
      r_sync_pipe <= {r_sync_pipe[0], {hs_in, vs_in, ad_in}};
    end
  end

  always_comb begin
    w_r = '0;
    w_g = '0;
    w_b = '0;
    case (r_s1_mode)
      3'd0: {w_r, w_g, w_b} = r_s1_color;
      3'd1: begin
        // bar order white,yellow,cyan,green,magenta,red,blue,black
        w_r = {COLOR_W{~r_s1_bar[1]}};
        w_g = {COLOR_W{~r_s1_bar[2]}};
        w_b = {COLOR_W{~r_s1_bar[0]}};
      end
      3'd2: begin
        if (r_s1_hx[TILE_LOG2] ^ r_s1_vc[TILE_LOG2]) begin
          w_r = '1; w_g = '1; w_b = '1;
        end
      end
      3'd3: begin
        w_r = COLOR_W'(r_s1_hx);
        w_g = COLOR_W'(r_s1_vc);
        w_b = ~COLOR_W'(r_s1_hx);
      end
      3'd4: begin
        if (r_s1_hx[GRID_LOG2-1:0] == '0 || r_s1_vc[GRID_LOG2-1:0] == '0) begin
          w_r = '1; w_g = '1; w_b = '1;
        end
      end
      default: ;
    endcase
    if (!r_sync_pipe[0][0]) begin
      w_r = '0;
      w_g = '0;
      w_b = '0;
    end
  end

  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      r_s2_r <= '0;
      r_s2_g <= '0;
      r_s2_b <= '0;
    end else begin
      r_s2_r <= w_r;
      r_s2_g <= w_g;
      r_s2_b <= w_b;
    end
  end

  assign red_out   = r_s2_r;
  assign green_out = r_s2_g;
  assign blue_out  = r_s2_b;
  assign hs_out    = r_sync_pipe[1][2];
  assign vs_out    = r_sync_pipe[1][1];
  assign ad_out    = r_sync_pipe[1][0];

endmodule
